// File: rtl/seq_divider.sv
`default_nettype none
// seq_divider: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU (quotient -> LO, remainder -> HI).
// Optional feature macro: DIV_ZERO_FAST_EN (divide-by-zero skips the iteration, IDLE -> DONE).
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               div_start,
   input  logic               div_signed,
   input  logic [WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               div_busy,
   output logic               div_ready,
   output logic [WIDTH-1:0]   quotient,
   output logic [2*WIDTH-1:0] remainder
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvsr;
   logic             r_q_neg;
   logic             r_r_neg;
   logic [WIDTH-1:0] r_q_out;
   logic [WIDTH-1:0] r_r_out;
   logic             r_ready;

   logic             w_start;
   logic             w_a_neg;
   logic             w_b_neg;
   logic             w_div_zero;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic             w_borrow;

   assign w_start    = (r_state == S_IDLE) && div_start;
   assign w_a_neg    = div_signed & dividend[WIDTH-1];
   assign w_b_neg    = div_signed & divisor[WIDTH-1];
   assign w_a_mag    = w_a_neg ? -dividend : dividend;
   assign w_b_mag    = w_b_neg ? -divisor  : divisor;
   assign w_div_zero = (divisor == '0);

   assign w_shift  = {r_rem, r_quo[WIDTH-1]};
   assign w_diff   = w_shift - {1'b0, r_dvsr};
   assign w_borrow = w_diff[WIDTH];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (div_start) begin
`ifdef DIV_ZERO_FAST_EN
               w_state_nxt = w_div_zero ? S_DONE : S_BUSY;
`else
               w_state_nxt = S_BUSY;
`endif
            end
         end
         S_BUSY:  w_state_nxt = (r_cnt == '0) ? S_DONE : S_BUSY;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_cnt   <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_dvsr  <= '0;
         r_q_neg <= 1'b0;
         r_r_neg <= 1'b0;
         r_q_out <= '0;
         r_r_out <= '0;
         r_ready <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         if (w_start) begin
            r_cnt <= CW'(WIDTH - 1);
            r_rem <= '0;
            if (w_div_zero) begin
               // Shifting the raw dividend past a zero divisor yields all-ones / dividend with no fixup.
               r_dvsr  <= '0;
               r_q_neg <= 1'b0;
               r_r_neg <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
               r_quo   <= '1;
               r_rem   <= dividend;
`else
               r_quo   <= dividend;
`endif
            end else begin
               r_dvsr  <= w_b_mag;
               r_quo   <= w_a_mag;
               r_q_neg <= w_a_neg ^ w_b_neg;
               r_r_neg <= w_a_neg;
            end
         end else if (r_state == S_BUSY) begin
            r_rem <= w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
            if (r_cnt != '0) begin
               r_cnt <= r_cnt - 1'b1;
            end
         end else if (r_state == S_DONE) begin
            r_q_out <= r_q_neg ? -r_quo : r_quo;
            r_r_out <= r_r_neg ? -r_rem : r_rem;
            r_ready <= 1'b1;
         end
      end
   end

   assign div_busy  = (r_state != S_IDLE);
   assign div_ready = r_ready;
   assign quotient  = r_q_out;
   assign remainder = {{WIDTH{1'b0}}, r_r_out};

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// tb_seq_divider: directed self-checking bench for seq_divider with hand-computed vectors.
module tb_seq_divider;

   localparam int WIDTH = 32;
`ifdef DIV_ZERO_FAST_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = WIDTH + 1;
`endif
   localparam int NLAT = WIDTH + 1;

   logic               CLK;
   logic               RST;
   logic               div_start;
   logic               div_signed;
   logic [WIDTH-1:0]   dividend;
   logic [WIDTH-1:0]   divisor;
   logic               div_busy;
   logic               div_ready;
   logic [WIDTH-1:0]   quotient;
   logic [2*WIDTH-1:0] remainder;

   int n_tot = 0;
   int n_bad = 0;

   seq_divider #(.WIDTH(WIDTH)) u_dut (
      .CLK        (CLK),
      .RST        (RST),
      .div_start  (div_start),
      .div_signed (div_signed),
      .dividend   (dividend),
      .divisor    (divisor),
      .div_busy   (div_busy),
      .div_ready  (div_ready),
      .quotient   (quotient),
      .remainder  (remainder)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_tot++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Launch one division; optionally fire a second (ignored) start inj edges after the first.
   task automatic run_div(input string tag, input logic sgn,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] eq, input logic [2*WIDTH-1:0] er,
                          input int elat, input int inj);
      int  lat;
      int  busy_low;
      bit  got;
      @(negedge CLK);
      div_start  = 1'b1;
      div_signed = sgn;
      dividend   = a;
      divisor    = b;
      @(posedge CLK);
      #1;
      div_start = 1'b0;
      dividend  = $urandom;
      divisor   = $urandom;
      check({tag, "_busy_at_start"}, {63'd0, div_busy}, 64'd1);
      lat      = 0;
      busy_low = 0;
      got      = 1'b0;
      while (!got && lat < 100) begin
         if (inj > 0 && lat + 1 == inj) begin
            div_start  = 1'b1;
            div_signed = 1'b0;
            dividend   = 32'd9;
            divisor    = 32'd3;
         end else begin
            div_start = 1'b0;
         end
         @(posedge CLK);
         #1;
         lat++;
         if (div_ready) got = 1'b1;
         else if (!div_busy) busy_low++;
      end
      div_start = 1'b0;
      check({tag, "_ready_seen"}, {63'd0, got}, 64'd1);
      check({tag, "_latency"}, 64'(lat), 64'(elat));
      check({tag, "_busy_held"}, 64'(busy_low), 64'd0);
      check({tag, "_quotient"}, {32'd0, quotient}, {32'd0, eq});
      check({tag, "_remainder"}, remainder, er);
      @(posedge CLK);
      #1;
      check({tag, "_ready_pulse"}, {63'd0, div_ready}, 64'd0);
   endtask

   initial begin
      int rdy_cnt;
      RST        = 1'b0;
      div_start  = 1'b0;
      div_signed = 1'b0;
      dividend   = '0;
      divisor    = '0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_quotient", {32'd0, quotient}, 64'd0);
      check("rst_remainder", remainder, 64'd0);
      check("rst_busy", {63'd0, div_busy}, 64'd0);
      check("rst_ready", {63'd0, div_ready}, 64'd0);
      @(negedge CLK);
      RST = 1'b1;

      run_div("divu_100_7",  1'b0, 32'd100,        32'd7,          32'd14,         64'd2,                  NLAT, 0);
      run_div("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  64'h0000_0000_FFFF_FFFF, NLAT, 0);
      run_div("div_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  64'd1,                  NLAT, 0);
      run_div("div_m8_m3",   1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          64'h0000_0000_FFFF_FFFE, NLAT, 0);
      run_div("div_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  64'd0,                  NLAT, 0);
      run_div("divu_big",    1'b0, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0FFF_FFFF,  64'hF,                  NLAT, 0);
      run_div("divu_5_0",    1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  64'd5,                  ZLAT, 0);
      run_div("div_5_0",     1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  64'd5,                  ZLAT, 0);
      run_div("div_m7_0",    1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFF9, ZLAT, 0);
      run_div("busy_ignore", 1'b0, 32'd100,        32'd7,          32'd14,         64'd2,                  NLAT, 10);

      repeat (3) @(posedge CLK);
      #1;
      check("hold_quotient", {32'd0, quotient}, 64'd14);
      check("hold_remainder", remainder, 64'd2);

      // Abort a division mid-flight with reset.
      @(negedge CLK);
      div_start  = 1'b1;
      div_signed = 1'b0;
      dividend   = 32'd1000;
      divisor    = 32'd3;
      @(posedge CLK);
      #1;
      div_start = 1'b0;
      repeat (14) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check("abort_quotient", {32'd0, quotient}, 64'd0);
      check("abort_remainder", remainder, 64'd0);
      check("abort_busy", {63'd0, div_busy}, 64'd0);
      check("abort_ready", {63'd0, div_ready}, 64'd0);
      @(negedge CLK);
      RST = 1'b1;
      rdy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge CLK);
         #1;
         if (div_ready) rdy_cnt++;
      end
      check("abort_no_ready", 64'(rdy_cnt), 64'd0);

      run_div("post_rst_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 64'd0, NLAT, 0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
